game_state_ctrl: RTL and testbench
==================================

# game_state_ctrl

Frame-level game sequencer for the paddle/ball/brick datapath. It owns the game phase (attract, serve, play, life lost, level clear, game over) and gates ball and paddle motion through `play_en`. It issues serve and brick-reload pulses, and tracks lives, level, ball speed and a saturating two-digit BCD score. It sits between the button inputs and the game datapath and runs on the pixel clock, with `frame` as its tick.

## Interface
- `CORDW`, 10: width of the `speed` output.
- `LIVES_INIT`, 3: lives at game start (1..7).
- `SERVE_FRAMES`, 60: frames held in SERVE before play starts (1..255).
- `OVER_FRAMES`, 180: frames held in OVER before returning to IDLE (1..255).
- `SPEED_INIT`, 5: ball speed in pixels/frame at level 1.
- `SPEED_MAX`, 9: speed saturation limit.

- `clk` input 1: pixel clock; single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `frame` input 1: one-cycle pulse at frame start.
- `btn1`, `btn2` input 1 each: raw asynchronous buttons, active-high.
- `ball_lost` input 1: level; ball is below the paddle.
- `bricks_clear` input 1: level; no active bricks remain.
- `brick_hit` input 1: one-cycle pulse per destroyed brick.
- `play_en` output 1: datapath may move ball and paddle.
- `serve` output 1: one-cycle pulse; datapath recentres ball and paddle.
- `bricks_reload` output 1: one-cycle pulse; datapath sets all bricks active.
- `lives` output 3: remaining lives.
- `level` output 4: current level, 1..15.
- `speed` output CORDW: ball speed.
- `score_tens`, `score_units` output 4 each: BCD score.
- `state` output 3: IDLE=0, SERVE=1, PLAY=2, LOST=3, CLEAR=4, OVER=5, PAUSE=6.

## Operation
**Buttons**
- `btn1` and `btn2` each pass through a 2-flop synchronizer, then a rising-edge detector.
- `press` = rising edge of either button.

**State machine** (all outputs registered)
- **IDLE:** `play_en`=0. On `press`:
  - Go to SERVE.
  - Load `lives`=LIVES_INIT, `level`=1, `speed`=SPEED_INIT, score=00.
  - Pulse `serve` and `bricks_reload`.
- **SERVE:** `play_en`=0.
  - A frame timer loads SERVE_FRAMES on entry and decrements on each `frame`.
  - On the `frame` that brings the timer from 1 to 0, go to PLAY.
- **PLAY:** `play_en`=1. Checked only on cycles with `frame`=1, priority highest first:
  - `bricks_clear` → CLEAR.
  - `ball_lost` → LOST.
- **LOST:** lasts one cycle. `lives` decrements.
  - If `lives` was 1: `lives`=0, go to OVER.
  - Otherwise go to SERVE and pulse `serve`.
- **CLEAR:** lasts one cycle.
  - `level`+1, saturating at 15.
  - `speed`+1, saturating at SPEED_MAX.
  - Pulse `serve` and `bricks_reload`, go to SERVE.
  - `lives` and score are unchanged.
- **OVER:** `play_en`=0.
  - Timer loads OVER_FRAMES and counts down on `frame`; at 0, go to IDLE.
  - `press` is ignored.
  - Score, level and lives stay visible until the next game starts.

**Score**
- Increments only when `brick_hit`=1 and `state`=PLAY, including the cycle on which PLAY is left.
- Units wrap 9→0 with a carry into tens.
- Saturates at 99.
- `brick_hit` outside PLAY is dropped.

**Inputs outside their states**
- `ball_lost` and `bricks_clear` are ignored outside PLAY.

## Timing
- **Reset values:**
  - `state`=IDLE, `play_en`=0, `serve`=0, `bricks_reload`=0.
  - `lives`=0, `level`=0, `speed`=SPEED_INIT, score=00, timers=0.
  - Synchronizer flops reset to 0.
- **Button latency:** a button rising edge changes `state` on the 3rd `clk` edge after the input rises (2 synchronizer flops + edge register).
- **Pulse alignment:** `serve` and `bricks_reload` are high for exactly one cycle, the same cycle `state` first shows the destination.
- **PLAY exits:** PLAY→LOST/CLEAR happens on the clock edge that samples `frame`=1. `play_en` drops on that same edge.
- **SERVE→PLAY:** `play_en` rises one cycle after the final `frame` pulse of SERVE.
- **Reset mid-game:** `rst_n` low clears all state immediately, whatever the current state.
- **Timer:** 8-bit.

## Configuration
- **`GAME_CTRL_PAUSE_EN` defined:**
  - Rising edge of (both synchronized buttons high) in PLAY → PAUSE, `play_en`=0.
  - The same event in PAUSE → PLAY.
  - In PAUSE, `ball_lost`, `bricks_clear` and `brick_hit` are ignored.
  - A both-button event does not also count as `press`.
- **Not defined:** the PAUSE state and its logic are absent; `state` never reads 6; a both-button press has no effect in PLAY.

## Test plan
- **Reset:** `rst_n` low mid-PLAY → next sample shows `state`=0, `play_en`=0, score=00, `speed`=5.
- **Start:** `btn1` pulse in IDLE → 3 cycles later `state`=1, `serve`=`bricks_reload`=1 for one cycle, `lives`=3, `level`=1; after 60 `frame` pulses `state`=2, `play_en`=1.
- **Lives:** `ball_lost` held in PLAY three times → `lives` 3→2→1→0; the third loss gives `state`=5; after 180 frames, `state`=0.
- **Level clear:** `bricks_clear` and `ball_lost` both high on a PLAY `frame` → CLEAR wins, `lives` unchanged, `level`=2, `speed`=6, `bricks_reload` pulses. Repeat to level 6 → `speed` stays 9.
- **Score:** 105 `brick_hit` pulses in PLAY → score 99 (tens=9, units=9). Pulses in SERVE → no change. Pulse on the PLAY-exit cycle → counted.
- **Pause (with `GAME_CTRL_PAUSE_EN`):** both buttons rise in PLAY → `state`=6, `play_en`=0, `ball_lost` ignored; both again → `state`=2.

Source files
------------

// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: controller <-> game datapath bundle.
// master is the sequencer side, slave the paddle/ball/brick side.
interface game_state_ctrl_if #(
  parameter int CORDW = 10
);
  logic             ball_lost;
  logic             bricks_clear;
  logic             brick_hit;
  logic             play_en;
  logic             serve;
  logic             bricks_reload;
  logic [2:0]       lives;
  logic [3:0]       level;
  logic [CORDW-1:0] speed;
  logic [3:0]       score_tens;
  logic [3:0]       score_units;
  logic [2:0]       state;

  modport master (
    input  ball_lost, bricks_clear, brick_hit,
    output play_en, serve, bricks_reload,
    output lives, level, speed,
    output score_tens, score_units, state
  );

  modport slave (
    output ball_lost, bricks_clear, brick_hit,
    input  play_en, serve, bricks_reload,
    input  lives, level, speed,
    input  score_tens, score_units, state
  );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame-level game phase sequencer.
// Define GAME_CTRL_PAUSE_EN to add the two-button PAUSE state.
module game_state_ctrl #(
  parameter int CORDW        = 10,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SPEED_INIT   = 5,
  parameter int SPEED_MAX    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame,
  input  logic btn1,
  input  logic btn2,
  game_state_ctrl_if.master dp
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_LOST  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;
`ifdef GAME_CTRL_PAUSE_EN
  localparam logic [2:0] S_PAUSE = 3'd6;
`endif

  localparam logic [7:0] T_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] T_OVER  = 8'(OVER_FRAMES);
  localparam logic [2:0] L_INIT  = 3'(LIVES_INIT);
  localparam logic [CORDW-1:0] SPD_INIT = CORDW'(SPEED_INIT);
  localparam logic [CORDW-1:0] SPD_MAX  = CORDW'(SPEED_MAX);

  logic [1:0] b1_sync_q, b2_sync_q;
  logic       b1_prev_q, b2_prev_q;
  logic       b1_rise, b2_rise, press;

  logic [2:0]       state_q, state_d;
  logic             play_en_q, play_en_d;
  logic             serve_q, serve_d;
  logic             reload_q, reload_d;
  logic [2:0]       lives_q, lives_d;
  logic [3:0]       level_q, level_d;
  logic [CORDW-1:0] speed_q, speed_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [7:0]       timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_sync_q <= 2'b00;
      b2_sync_q <= 2'b00;
      b1_prev_q <= 1'b0;
      b2_prev_q <= 1'b0;
    end else begin
      b1_sync_q <= {b1_sync_q[0], btn1};
      b2_sync_q <= {b2_sync_q[0], btn2};
      b1_prev_q <= b1_sync_q[1];
      b2_prev_q <= b2_sync_q[1];
    end
  end

  assign b1_rise = b1_sync_q[1] & ~b1_prev_q;
  assign b2_rise = b2_sync_q[1] & ~b2_prev_q;

`ifdef GAME_CTRL_PAUSE_EN
  logic both_now, both_prev_q, both_rise;

  assign both_now = b1_sync_q[1] & b2_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) both_prev_q <= 1'b0;
    else        both_prev_q <= both_now;
  end

  assign both_rise = both_now & ~both_prev_q;
  // a chord is a pause toggle, never a start press
  assign press = (b1_rise | b2_rise) & ~both_rise;
`else
  assign press = b1_rise | b2_rise;
`endif

  always_comb begin
    state_d   = state_q;
    play_en_d = play_en_q;
    serve_d   = 1'b0;
    reload_d  = 1'b0;
    lives_d   = lives_q;
    level_d   = level_q;
    speed_d   = speed_q;
    tens_d    = tens_q;
    units_d   = units_q;
    timer_d   = timer_q;

    // counts on the PLAY exit cycle too
    if (state_q == S_PLAY && dp.brick_hit) begin
      if (units_q != 4'd9) begin
        units_d = units_q + 4'd1;
      end else if (tens_q != 4'd9) begin
        units_d = 4'd0;
        tens_d  = tens_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d  = S_SERVE;
          serve_d  = 1'b1;
          reload_d = 1'b1;
          lives_d  = L_INIT;
          level_d  = 4'd1;
          speed_d  = SPD_INIT;
          tens_d   = 4'd0;
          units_d  = 4'd0;
          timer_d  = T_SERVE;
        end
      end
      S_SERVE: begin
        if (frame) begin
          timer_d = timer_q - 8'd1;
          if (timer_q <= 8'd1) begin
            state_d   = S_PLAY;
            play_en_d = 1'b1;
            timer_d   = 8'd0;
          end
        end
      end
      S_PLAY: begin
        if (frame && dp.bricks_clear) begin
          state_d   = S_CLEAR;
          play_en_d = 1'b0;
        end else if (frame && dp.ball_lost) begin
          state_d   = S_LOST;
          play_en_d = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
        end else if (both_rise) begin
          state_d   = S_PAUSE;
          play_en_d = 1'b0;
`endif
        end
      end
      S_LOST: begin
        if (lives_q <= 3'd1) begin
          lives_d = 3'd0;
          state_d = S_OVER;
          timer_d = T_OVER;
        end else begin
          lives_d = lives_q - 3'd1;
          state_d = S_SERVE;
          serve_d = 1'b1;
          timer_d = T_SERVE;
        end
      end
      S_CLEAR: begin
        if (level_q != 4'd15) level_d = level_q + 4'd1;
        if (speed_q < SPD_MAX) speed_d = speed_q + 1'b1;
        state_d  = S_SERVE;
        serve_d  = 1'b1;
        reload_d = 1'b1;
        timer_d  = T_SERVE;
      end
      S_OVER: begin
        if (frame) begin
          timer_d = timer_q - 8'd1;
          if (timer_q <= 8'd1) begin
            state_d = S_IDLE;
            timer_d = 8'd0;
          end
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (both_rise) begin
          state_d   = S_PLAY;
          play_en_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d   = S_IDLE;
        play_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      play_en_q <= 1'b0;
      serve_q   <= 1'b0;
      reload_q  <= 1'b0;
      lives_q   <= 3'd0;
      level_q   <= 4'd0;
      speed_q   <= SPD_INIT;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      timer_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      play_en_q <= play_en_d;
      serve_q   <= serve_d;
      reload_q  <= reload_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      speed_q   <= speed_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      timer_q   <= timer_d;
    end
  end

  assign dp.state         = state_q;
  assign dp.play_en       = play_en_q;
  assign dp.serve         = serve_q;
  assign dp.bricks_reload = reload_q;
  assign dp.lives         = lives_q;
  assign dp.level         = level_q;
  assign dp.speed         = speed_q;
  assign dp.score_tens    = tens_q;
  assign dp.score_units   = units_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: randomized game sequences vs a rule-level model.
// Build with GAME_CTRL_PAUSE_EN to exercise the pause chord.
module tb_game_state_ctrl;
  localparam int CORDW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic frame = 1'b0;
  logic btn1  = 1'b0;
  logic btn2  = 1'b0;

  int nchk = 0;
  int nerr = 0;

  int m_state = 0;
  int m_lives = 0;
  int m_level = 0;
  int m_speed = 5;
  int m_score = 0;

  game_state_ctrl_if #(.CORDW(CORDW)) gio ();

  game_state_ctrl #(.CORDW(CORDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .frame (frame),
    .btn1  (btn1),
    .btn2  (btn2),
    .dp    (gio)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] got_v();
    return {gio.state, gio.play_en, gio.lives,
            gio.level, gio.speed,
            gio.score_tens, gio.score_units};
  endfunction

  function automatic logic [28:0] want_v();
    return {3'(m_state), (m_state == 2),
            3'(m_lives), 4'(m_level),
            10'(m_speed), 4'(m_score / 10),
            4'(m_score % 10)};
  endfunction

  function automatic void score_up();
    m_score = (m_score < 99) ? m_score + 1 : 99;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    frame = 1'b1;
    cyc();
    frame = 1'b0;
    cyc();
  endtask

  task automatic serve_to_play();
    repeat (60) do_frame();
    m_state = 2;
  endtask

  task automatic start_game(input logic use2);
    if (use2) btn2 = 1'b1;
    else      btn1 = 1'b1;
    repeat (3) cyc();
    btn1 = 1'b0;
    btn2 = 1'b0;
    m_state = 1;
    m_lives = 3;
    m_level = 1;
    m_speed = 5;
    m_score = 0;
    repeat (3) cyc();
  endtask

  task automatic hit_once(input logic with_frame);
    gio.brick_hit = 1'b1;
    frame = with_frame;
    cyc();
    gio.brick_hit = 1'b0;
    frame = 1'b0;
    if (m_state == 2) score_up();
    repeat ($urandom_range(0, 3)) cyc();
  endtask

  task automatic lose_ball(input logic hit);
    gio.ball_lost = 1'b1;
    gio.brick_hit = hit;
    frame = 1'b1;
    cyc();
    if (hit) score_up();
    gio.ball_lost = 1'b0;
    gio.brick_hit = 1'b1;
    frame = 1'b0;
    cyc();
    gio.brick_hit = 1'b0;
    m_lives = m_lives - 1;
    m_state = (m_lives == 0) ? 5 : 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL reset_state: got %h want %h",
               got_v(), want_v());
    end
    nchk++;
    if ({gio.serve, gio.bricks_reload} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_pulses: got %b want 00",
               {gio.serve, gio.bricks_reload});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_start();
    btn1 = 1'b1;
    cyc();
    cyc();
    nchk++;
    if (gio.state !== 3'd0) begin
      nerr++;
      $display("FAIL start_early: got %0d want 0", gio.state);
    end
    cyc();
    m_state = 1;
    m_lives = 3;
    m_level = 1;
    m_speed = 5;
    m_score = 0;
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL start_state: got %h want %h",
               got_v(), want_v());
    end
    nchk++;
    if ({gio.serve, gio.bricks_reload} !== 2'b11) begin
      nerr++;
      $display("FAIL start_pulses: got %b want 11",
               {gio.serve, gio.bricks_reload});
    end
    btn1 = 1'b0;
    cyc();
    nchk++;
    if ({gio.serve, gio.bricks_reload} !== 2'b00) begin
      nerr++;
      $display("FAIL start_pulse_len: got %b want 00",
               {gio.serve, gio.bricks_reload});
    end
    cyc();
    cyc();
    repeat (59) do_frame();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL serve_59: got %h want %h",
               got_v(), want_v());
    end
    frame = 1'b1;
    cyc();
    frame = 1'b0;
    m_state = 2;
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL serve_60: got %h want %h",
               got_v(), want_v());
    end
    cyc();
  endtask

  task automatic test_score();
    int n;
    n = $urandom_range(15, 30);
    for (int i = 0; i < n; i++) hit_once(1'($urandom_range(0, 1)));
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL score_rand: got %h want %h",
               got_v(), want_v());
    end
    lose_ball(1'b1);
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL score_exit: got %h want %h",
               got_v(), want_v());
    end
    repeat (5) begin
      gio.brick_hit = 1'b1;
      cyc();
      gio.brick_hit = 1'b0;
      cyc();
    end
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL score_serve: got %h want %h",
               got_v(), want_v());
    end
    serve_to_play();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL score_replay: got %h want %h",
               got_v(), want_v());
    end
  endtask

  task automatic test_both_buttons();
    btn1 = 1'b1;
    btn2 = 1'b1;
    repeat (3) cyc();
`ifdef GAME_CTRL_PAUSE_EN
    m_state = 6;
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL pause_enter: got %h want %h",
               got_v(), want_v());
    end
    gio.ball_lost = 1'b1;
    gio.bricks_clear = 1'b1;
    gio.brick_hit = 1'b1;
    frame = 1'b1;
    cyc();
    gio.ball_lost = 1'b0;
    gio.bricks_clear = 1'b0;
    gio.brick_hit = 1'b0;
    frame = 1'b0;
    cyc();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL pause_ignore: got %h want %h",
               got_v(), want_v());
    end
    btn1 = 1'b0;
    btn2 = 1'b0;
    repeat (3) cyc();
    btn1 = 1'b1;
    btn2 = 1'b1;
    repeat (3) cyc();
    m_state = 2;
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL pause_exit: got %h want %h",
               got_v(), want_v());
    end
`else
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL chord_nop: got %h want %h",
               got_v(), want_v());
    end
`endif
    btn1 = 1'b0;
    btn2 = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_level_clear();
    for (int k = 0; k < 5; k++) begin
      gio.bricks_clear = 1'b1;
      gio.ball_lost = 1'b1;
      frame = 1'b1;
      cyc();
      m_state = 4;
      nchk++;
      if (got_v() !== want_v()) begin
        nerr++;
        $display("FAIL clear_enter%0d: got %h want %h",
                 k, got_v(), want_v());
      end
      gio.bricks_clear = 1'b0;
      gio.ball_lost = 1'b0;
      frame = 1'b0;
      cyc();
      m_state = 1;
      m_level = (m_level < 15) ? m_level + 1 : 15;
      m_speed = (m_speed < 9) ? m_speed + 1 : 9;
      nchk++;
      if (got_v() !== want_v()) begin
        nerr++;
        $display("FAIL clear_level%0d: got %h want %h",
                 k, got_v(), want_v());
      end
      nchk++;
      if ({gio.serve, gio.bricks_reload} !== 2'b11) begin
        nerr++;
        $display("FAIL clear_pulses%0d: got %b want 11",
                 k, {gio.serve, gio.bricks_reload});
      end
      cyc();
      serve_to_play();
    end
  endtask

  task automatic test_score_sat();
    repeat (105) hit_once(1'b0);
    nchk++;
    if ({gio.score_tens, gio.score_units} !== 8'h99) begin
      nerr++;
      $display("FAIL score_sat: got %h want 99",
               {gio.score_tens, gio.score_units});
    end
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL score_sat_all: got %h want %h",
               got_v(), want_v());
    end
  endtask

  task automatic test_lives();
    while (m_lives > 0) begin
      lose_ball(1'b0);
      nchk++;
      if (got_v() !== want_v()) begin
        nerr++;
        $display("FAIL lives_%0d: got %h want %h",
                 m_lives, got_v(), want_v());
      end
      nchk++;
      if (gio.serve !== (m_state == 1)) begin
        nerr++;
        $display("FAIL lives_serve%0d: got %b want %b",
                 m_lives, gio.serve, (m_state == 1));
      end
      if (m_state == 1) serve_to_play();
    end
    btn2 = 1'b1;
    repeat (4) cyc();
    btn2 = 1'b0;
    repeat (3) cyc();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL over_press: got %h want %h",
               got_v(), want_v());
    end
    repeat (179) do_frame();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL over_179: got %h want %h",
               got_v(), want_v());
    end
    do_frame();
    m_state = 0;
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL over_idle: got %h want %h",
               got_v(), want_v());
    end
  endtask

  task automatic test_random();
    int op;
    for (int g = 0; g < 2; g++) begin
      start_game(1'($urandom_range(0, 1)));
      serve_to_play();
      for (int i = 0; i < 40 && m_state != 5; i++) begin
        op = $urandom_range(0, 9);
        if (op < 5) begin
          hit_once(1'($urandom_range(0, 1)));
        end else if (op < 7) begin
          do_frame();
        end else if (op == 7) begin
          lose_ball(1'($urandom_range(0, 1)));
        end else begin
          gio.bricks_clear = 1'b1;
          gio.ball_lost = 1'($urandom_range(0, 1));
          gio.brick_hit = 1'($urandom_range(0, 1));
          frame = 1'b1;
          cyc();
          if (gio.brick_hit) score_up();
          gio.bricks_clear = 1'b0;
          gio.ball_lost = 1'b0;
          gio.brick_hit = 1'b0;
          frame = 1'b0;
          cyc();
          m_state = 1;
          m_level = (m_level < 15) ? m_level + 1 : 15;
          m_speed = (m_speed < 9) ? m_speed + 1 : 9;
        end
        nchk++;
        if (got_v() !== want_v()) begin
          nerr++;
          $display("FAIL rand_g%0d_op%0d: got %h want %h",
                   g, i, got_v(), want_v());
        end
        if (m_state == 1) serve_to_play();
      end
      if (m_state == 5) begin
        repeat (180) do_frame();
        m_state = 0;
      end else begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        m_state = 0;
        m_lives = 0;
        m_level = 0;
        m_speed = 5;
        m_score = 0;
      end
      nchk++;
      if (got_v() !== want_v()) begin
        nerr++;
        $display("FAIL rand_end%0d: got %h want %h",
                 g, got_v(), want_v());
      end
    end
  endtask

  task automatic test_reset_mid();
    start_game(1'b0);
    serve_to_play();
    repeat (7) hit_once(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_state = 0;
    m_lives = 0;
    m_level = 0;
    m_speed = 5;
    m_score = 0;
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL reset_mid: got %h want %h",
               got_v(), want_v());
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    nchk++;
    if (got_v() !== want_v()) begin
      nerr++;
      $display("FAIL reset_release: got %h want %h",
               got_v(), want_v());
    end
  endtask

  initial begin
    gio.ball_lost    = 1'b0;
    gio.bricks_clear = 1'b0;
    gio.brick_hit    = 1'b0;
    test_reset();
    test_start();
    test_score();
    test_both_buttons();
    test_level_clear();
    test_score_sat();
    test_lives();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nerr);
    $finish;
  end

endmodule
